seven_segment_scan_driver: RTL and testbench

- Time-multiplexed driver for an N-digit common-anode seven-segment display.
- Accepts a packed vector of 4-bit glyph codes plus per-digit decimal-point and blank masks.
- Decodes one digit per scan slot and drives active-low segments and digit enables.
- Adds a scan timer, an anti-ghosting dead time, frame-coherent input capture, enable gating and leading-zero suppression.
- Sits between the RSA control/status logic and the board display pins.

---
 rtl/seven_segment_scan_driver.sv | 146 ++++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// One digit is lit per scan slot. Each slot opens with a dead time in which
// every digit is off, so the previous digit's segments cannot ghost onto the
// next one. Inputs are captured once per frame so a display never tears.
module seven_segment_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            en,
  input  logic [4*N_DIGITS-1:0]                           codes,
  input  logic [N_DIGITS-1:0]                             dps,
  input  logic [N_DIGITS-1:0]                             blank,
  input  logic                                            lzs,
  output logic [6:0]                                      seg,
  output logic                                            dp_n,
  output logic [N_DIGITS-1:0]                             an,
  output logic [(N_DIGITS > 1 ? $clog2(N_DIGITS) : 1)-1:0] digit_idx
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0]           cnt;
  logic [IW-1:0]           idx;
  logic                    first;
  logic [4*N_DIGITS-1:0]   codesSnap;
  logic [N_DIGITS-1:0]     dpsSnap;
  logic [N_DIGITS-1:0]     blankSnap;
  logic                    lzsSnap;

  logic                    slotEnd;
  logic                    frameEnd;
  logic [N_DIGITS-1:0]     suppress;
  logic                    allZero;
  logic [3:0]              curCode;
  logic                    curDp;
  logic                    curBlank;
  logic                    curSupp;
  logic [N_DIGITS-1:0]     anLit;
  logic                    dark;

  // Glyph ROM, segment order {a,b,c,d,e,f,g}, active-low.
  function automatic logic [6:0] glyph(input logic [3:0] c);
    case (c)
      4'h0:    glyph = 7'b0000001;
      4'h1:    glyph = 7'b1001111;
      4'h2:    glyph = 7'b0010010;
      4'h3:    glyph = 7'b0000110;
      4'h4:    glyph = 7'b1001100;
      4'h5:    glyph = 7'b0100100;
      4'h6:    glyph = 7'b0100000;
      4'h7:    glyph = 7'b0001111;
      4'h8:    glyph = 7'b0000000;
      4'h9:    glyph = 7'b0000100;
      4'hA:    glyph = 7'b1111110;
      4'hB:    glyph = 7'b0011000;
      4'hC:    glyph = 7'b0110001;
      4'hD:    glyph = 7'b1101010;
      4'hE:    glyph = 7'b1000010;
      default: glyph = 7'b1000001;
    endcase
  endfunction

  assign slotEnd   = (cnt == CW'(SCAN_DIV - 1));
  assign frameEnd  = slotEnd && (idx == IW'(N_DIGITS - 1));
  assign digit_idx = idx;

  // Slot timer and digit index; both freeze while the scan is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (slotEnd) begin
        cnt <= '0;
        idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Input capture: once right after reset, then only at frame boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first     <= 1'b1;
      codesSnap <= '0;
      dpsSnap   <= '0;
      blankSnap <= '0;
      lzsSnap   <= 1'b0;
    end else if (en && (first || frameEnd)) begin
      first     <= 1'b0;
      codesSnap <= codes;
      dpsSnap   <= dps;
      blankSnap <= blank;
      lzsSnap   <= lzs;
    end
  end

  // Leading-zero map (scanned from the top digit down), current-digit select
  // and the dark decision for this cycle.
  always_comb begin
    suppress = '0;
    allZero  = 1'b1;
    curCode  = 4'h0;
    curDp    = 1'b0;
    curBlank = 1'b0;
    curSupp  = 1'b0;
    anLit    = '1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      allZero     = allZero & (codesSnap[4*k +: 4] == 4'h0);
      suppress[k] = lzsSnap & allZero & (k != 0);
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      anLit[k] = (idx != IW'(k));
      if (idx == IW'(k)) begin
        curCode  = codesSnap[4*k +: 4];
        curDp    = dpsSnap[k];
        curBlank = blankSnap[k];
        curSupp  = suppress[k];
      end
    end
    dark = !en || (cnt < CW'(DEAD_CYC)) || curBlank || curSupp;
  end

  // Registered pin drivers; dark forces every enable and segment off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg  <= 7'h7F;
      dp_n <= 1'b1;
      an   <= '1;
    end else if (dark) begin
      seg  <= 7'h7F;
      dp_n <= 1'b1;
      an   <= '1;
    end else begin
      seg  <= glyph(curCode);
      dp_n <= ~curDp;
      an   <= anLit;
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Scenario bench for seven_segment_scan_driver (N_DIGITS=4, SCAN_DIV=4,
// DEAD_CYC=1). A cycle model pushes the expected pins for each clock into a
// queue; each scenario pops and compares after the edge, and adds its own
// fixed expectations for the visible display pattern.
module tb_seven_segment_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] codes = '0;
  logic [3:0]  dps = '0;
  logic [3:0]  blank = '0;
  logic        lzs = 1'b0;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int testsRun = 0;
  int testsFailed = 0;

  logic [6:0] glyphTab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b1111110, 7'b0011000,
    7'b0110001, 7'b1101010, 7'b1000010, 7'b1000001};

  // model state
  int          mCnt, mIdx;
  logic        mFirst;
  logic [15:0] mCodes;
  logic [3:0]  mDps, mBlank;
  logic        mLzs;
  logic [13:0] expQ [$];

  seven_segment_scan_driver #(.N_DIGITS(4), .SCAN_DIV(4), .DEAD_CYC(1)) dut (
    .clk(clk), .rst(rst), .en(en), .codes(codes), .dps(dps), .blank(blank),
    .lzs(lzs), .seg(seg), .dp_n(dp_n), .an(an), .digit_idx(digit_idx));

  always #5 clk = ~clk;

  task automatic model_reset();
    mCnt = 0; mIdx = 0; mFirst = 1'b1;
    mCodes = '0; mDps = '0; mBlank = '0; mLzs = 1'b0;
    expQ.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Predict the pins produced by the coming edge, advance the model, then
  // step past the edge.
  task automatic tick();
    logic [3:0] eAn;
    logic [6:0] eSeg;
    logic       eDp;
    logic [3:0] code;
    code = 4'(mCodes >> (4 * mIdx));
    if (!en || mCnt < 1 || mBlank[mIdx] ||
        (mLzs && mIdx > 0 && (mCodes >> (4 * mIdx)) == 16'h0)) begin
      eAn = 4'hF; eSeg = 7'h7F; eDp = 1'b1;
    end else begin
      eAn = ~(4'b0001 << mIdx); eSeg = glyphTab[code]; eDp = ~mDps[mIdx];
    end
    if (en) begin
      if (mFirst || (mCnt == 3 && mIdx == 3)) begin
        mCodes = codes; mDps = dps; mBlank = blank; mLzs = lzs; mFirst = 1'b0;
      end
      if (mCnt == 3) begin mCnt = 0; mIdx = (mIdx + 1) % 4; end
      else mCnt = mCnt + 1;
    end
    expQ.push_back({eAn, eSeg, eDp, 2'(mIdx)});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    testsRun++;
    if (seg !== 7'h7F) begin testsFailed++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'h7F); end
    testsRun++;
    if (dp_n !== 1'b1) begin testsFailed++; $display("FAIL reset_dp got=%b exp=1", dp_n); end
    testsRun++;
    if (an !== 4'hF) begin testsFailed++; $display("FAIL reset_an got=%b exp=1111", an); end
    testsRun++;
    if (digit_idx !== 2'd0) begin testsFailed++; $display("FAIL reset_idx got=%0d exp=0", digit_idx); end
  endtask

  task automatic test_basic_scan();
    logic [3:0]  litAn  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  litSeg [4] = '{7'b1001111, 7'b0010010, 7'b0110001, 7'b0011000};
    logic        litDp  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [13:0] e;
    do_reset();
    codes = 16'hBC21; dps = 4'b0100; blank = '0; lzs = 1'b0; en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      tick();
      e = expQ.pop_front();
      testsRun++;
      if ({an, seg, dp_n, digit_idx} !== e) begin
        testsFailed++; $display("FAIL basic_model i=%0d got=%h exp=%h", i, {an, seg, dp_n, digit_idx}, e);
      end
      testsRun++;
      if ((i % 4) == 0) begin
        if ({an, seg, dp_n} !== {4'hF, 7'h7F, 1'b1}) begin
          testsFailed++; $display("FAIL basic_dead i=%0d got an=%b seg=%b", i, an, seg);
        end
      end else if ({an, seg, dp_n} !== {litAn[(i/4)%4], litSeg[(i/4)%4], litDp[(i/4)%4]}) begin
        testsFailed++; $display("FAIL basic_lit i=%0d got an=%b seg=%b dp=%b", i, an, seg, dp_n);
      end
    end
  endtask

  task automatic test_frame_coherence();
    logic [13:0] e;
    logic [15:0] shown;
    logic [3:0]  nib;
    do_reset();
    codes = 16'h1234; dps = '0; blank = '0; lzs = 1'b0; en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i == 6) codes = 16'h5678;
      tick();
      e = expQ.pop_front();
      testsRun++;
      if ({an, seg, dp_n, digit_idx} !== e) begin
        testsFailed++; $display("FAIL coherence_model i=%0d got=%h exp=%h", i, {an, seg, dp_n, digit_idx}, e);
      end
      if ((i % 4) != 0) begin
        shown = (i < 16) ? 16'h1234 : 16'h5678;
        nib = 4'(shown >> (4 * ((i / 4) % 4)));
        testsRun++;
        if (seg !== glyphTab[nib]) begin
          testsFailed++; $display("FAIL coherence_seg i=%0d got=%b exp=%b", i, seg, glyphTab[nib]);
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [13:0] e;
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      codes = (pass == 0) ? 16'h0005 : 16'h0000;
      dps = '0; blank = '0; lzs = 1'b1; en = 1'b1;
      for (int i = 0; i < 16; i++) begin
        tick();
        e = expQ.pop_front();
        testsRun++;
        if ({an, seg, dp_n, digit_idx} !== e) begin
          testsFailed++; $display("FAIL lzs_model p=%0d i=%0d got=%h exp=%h", pass, i, {an, seg, dp_n, digit_idx}, e);
        end
        testsRun++;
        if (i >= 4) begin
          if (an !== 4'hF) begin
            testsFailed++; $display("FAIL lzs_dark p=%0d i=%0d got an=%b exp=1111", pass, i, an);
          end
        end else if (i != 0) begin
          if ({an, seg} !== {4'b1110, (pass == 0) ? 7'b0100100 : 7'b0000001}) begin
            testsFailed++; $display("FAIL lzs_digit0 p=%0d i=%0d got an=%b seg=%b", pass, i, an, seg);
          end
        end else if (an !== 4'hF) begin
          testsFailed++; $display("FAIL lzs_dead p=%0d got an=%b exp=1111", pass, an);
        end
      end
    end
  endtask

  task automatic test_blank_enable();
    logic [13:0] e;
    do_reset();
    codes = 16'h1234; dps = 4'b1111; blank = 4'b0010; lzs = 1'b0; en = 1'b1;
    for (int i = 0; i < 30; i++) begin
      en = (i >= 10 && i < 20) ? 1'b0 : 1'b1;
      tick();
      e = expQ.pop_front();
      testsRun++;
      if ({an, seg, dp_n, digit_idx} !== e) begin
        testsFailed++; $display("FAIL blank_model i=%0d got=%h exp=%h", i, {an, seg, dp_n, digit_idx}, e);
      end
      if (i >= 4 && i < 8) begin
        testsRun++;
        if (an !== 4'hF) begin testsFailed++; $display("FAIL blank_slot1 i=%0d got an=%b exp=1111", i, an); end
      end
      if (i >= 10 && i < 20) begin
        testsRun++;
        if ({an, seg, dp_n, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd2}) begin
          testsFailed++; $display("FAIL enable_hold i=%0d got an=%b seg=%b idx=%0d exp an=1111 idx=2", i, an, seg, digit_idx);
        end
      end
      if (i == 20 || i == 21) begin
        testsRun++;
        if ({an, seg} !== {4'b1011, glyphTab[2]}) begin
          testsFailed++; $display("FAIL enable_resume i=%0d got an=%b seg=%b", i, an, seg);
        end
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [13:0] e;
    do_reset();
    codes = 16'h1234; dps = '0; blank = '0; lzs = 1'b0; en = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      e = expQ.pop_front();
      testsRun++;
      if ({an, seg, dp_n, digit_idx} !== e) begin
        testsFailed++; $display("FAIL areset_pre i=%0d got=%h exp=%h", i, {an, seg, dp_n, digit_idx}, e);
      end
    end
    #2;
    rst = 1'b1;
    #1;
    testsRun++;
    if ({an, seg, dp_n, digit_idx} !== {4'hF, 7'h7F, 1'b1, 2'd0}) begin
      testsFailed++; $display("FAIL areset_async got an=%b seg=%b dp=%b idx=%0d exp an=1111 seg=1111111 idx=0", an, seg, dp_n, digit_idx);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    codes = 16'h9ABC;
    for (int i = 0; i < 16; i++) begin
      tick();
      e = expQ.pop_front();
      testsRun++;
      if ({an, seg, dp_n, digit_idx} !== e) begin
        testsFailed++; $display("FAIL areset_post i=%0d got=%h exp=%h", i, {an, seg, dp_n, digit_idx}, e);
      end
      if (i == 1 || i == 13) begin
        testsRun++;
        if (seg !== ((i == 1) ? glyphTab[12] : glyphTab[9])) begin
          testsFailed++; $display("FAIL areset_snap i=%0d got seg=%b", i, seg);
        end
      end
    end
  endtask

  task automatic test_glyphs();
    logic [13:0] e;
    for (int v = 0; v < 16; v++) begin
      do_reset();
      codes = {12'h000, 4'(v)}; dps = '0; blank = '0; lzs = 1'b0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
        tick();
        e = expQ.pop_front();
        testsRun++;
        if ({an, seg, dp_n, digit_idx} !== e) begin
          testsFailed++; $display("FAIL glyph_model v=%0d i=%0d got=%h exp=%h", v, i, {an, seg, dp_n, digit_idx}, e);
        end
        testsRun++;
        if ($countones(~an) > 1) begin
          testsFailed++; $display("FAIL one_cold v=%0d got an=%b", v, an);
        end
        if (i == 1) begin
          testsRun++;
          if (seg !== glyphTab[v]) begin
            testsFailed++; $display("FAIL glyph_seg code=%h got=%b exp=%b", v, seg, glyphTab[v]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_frame_coherence();
    test_leading_zeros();
    test_blank_enable();
    test_async_reset();
    test_glyphs();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
